// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        SAMPLE = 1'b1
    } scan_state_t;

    localparam int unsigned POP_W = 64;

    function automatic int unsigned code_w(input int unsigned n_keys);
        return (n_keys > 2) ? $clog2(n_keys) : 1;
    endfunction

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_W; i++)
            n = n + {31'b0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: commits a frame once it has been seen DEBOUNCE_FRAMES
// times in a row and differs from the current debounced state.
module keypad_frame_debounce #(
    parameter int unsigned N_BITS          = 16,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_BITS-1:0] i_frame,
    input  logic              i_frame_done,
    output logic [N_BITS-1:0] o_debounced,
    output logic              o_commit
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

    logic [N_BITS-1:0] r_prev_frame;
    logic [N_BITS-1:0] r_debounced;
    logic [CNT_W-1:0]  r_stable_cnt;
    logic [CNT_W-1:0]  w_cnt_next;

    always_comb begin
        w_cnt_next = r_stable_cnt;
        if (i_frame != r_prev_frame)
            w_cnt_next = CNT_W'(1);
        else if (r_stable_cnt != CNT_MAX)
            w_cnt_next = r_stable_cnt + 1'b1;
    end

    // Commit decision includes the frame completing this cycle
    assign o_commit    = i_frame_done && (w_cnt_next == CNT_MAX) && (i_frame != r_debounced);
    assign o_debounced = r_debounced;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_frame <= '0;
            r_debounced  <= '0;
            r_stable_cnt <= '0;
        end else if (i_frame_done) begin
            r_stable_cnt <= w_cnt_next;
            r_prev_frame <= i_frame;
            if (o_commit)
                r_debounced <= i_frame;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-strobed keypad matrix scanner with column synchroniser, frame debounce
// and registered press/release/held/multi outputs.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned N_ROWS          = 4,
    parameter int unsigned N_COLS          = 4,
    parameter int unsigned SETTLE_CYCLES   = 8,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    output logic [N_ROWS-1:0]                   o_row,
    input  logic [N_COLS-1:0]                   i_col,
    output logic [code_w(N_ROWS*N_COLS)-1:0]    o_key_code,
    output logic                                o_key_press,
    output logic                                o_key_release,
    output logic                                o_key_held,
    output logic                                o_key_multi
);

    localparam int unsigned N_KEYS = N_ROWS * N_COLS;
    localparam int unsigned CODE_W = code_w(N_KEYS);
    localparam int unsigned ROW_W  = $clog2(N_ROWS);
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES);

    logic [N_COLS-1:0] r_col_meta;
    logic [N_COLS-1:0] r_col_sync;
    scan_state_t       r_state;
    scan_state_t       w_state_next;
    logic [SET_W-1:0]  r_settle_cnt;
    logic [ROW_W-1:0]  r_row_idx;
    logic [N_ROWS-1:0] r_row;
    logic [N_KEYS-1:0] r_frame;
    logic [N_KEYS-1:0] w_frame_full;
    logic [N_KEYS-1:0] w_debounced;
    logic [N_KEYS-1:0] w_deb_next;
    logic              w_last_settle;
    logic              w_last_row;
    logic              w_frame_done;
    logic              w_commit;
    int unsigned       w_pop;
    logic [CODE_W-1:0] w_code;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_press;
    logic              r_key_release;
    logic              r_key_held;
    logic              r_key_multi;

    assign w_last_settle = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign w_last_row    = (r_row_idx == ROW_W'(N_ROWS - 1));
    assign w_frame_done  = (r_state == SAMPLE) && w_last_row;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= SETTLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SETTLE:  if (w_last_settle) w_state_next = SAMPLE;
            SAMPLE:  w_state_next = SETTLE;
            default: w_state_next = SETTLE;
        endcase
    end

    // Frame as it will look once the current row's sample is written
    always_comb begin
        w_frame_full = r_frame;
        w_frame_full[r_row_idx*N_COLS +: N_COLS] = r_col_sync;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col_meta   <= '0;
            r_col_sync   <= '0;
            r_settle_cnt <= '0;
            r_row_idx    <= '0;
            r_row        <= N_ROWS'(1);
            r_frame      <= '0;
        end else begin
            r_col_meta <= i_col;
            r_col_sync <= r_col_meta;
            if (r_state == SETTLE)
                r_settle_cnt <= w_last_settle ? '0 : r_settle_cnt + 1'b1;
            else
                r_settle_cnt <= '0;
            if (r_state == SAMPLE) begin
                r_frame <= w_frame_full;
                if (w_last_row) begin
                    r_row_idx <= '0;
                    r_row     <= N_ROWS'(1);
                end else begin
                    r_row_idx <= r_row_idx + 1'b1;
                    r_row     <= r_row << 1;
                end
            end
        end
    end

    keypad_frame_debounce #(
        .N_BITS          (N_KEYS),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_frame      (w_frame_full),
        .i_frame_done (w_frame_done),
        .o_debounced  (w_debounced),
        .o_commit     (w_commit)
    );

    // Flags track the debounced state including a commit landing this cycle
    always_comb begin
        w_deb_next = w_commit ? w_frame_full : w_debounced;
        w_pop      = popcount(POP_W'(w_deb_next));
        w_code     = '0;
        for (int unsigned i = 0; i < N_KEYS; i++)
            if (w_frame_full[i])
                w_code = CODE_W'(i);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_code    <= '0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_held    <= 1'b0;
            r_key_multi   <= 1'b0;
        end else begin
            r_key_press   <= w_commit && (w_pop == 1);
            r_key_release <= w_commit && (w_pop == 0);
            if (w_commit && (w_pop == 1))
                r_key_code <= w_code;
            r_key_held    <= (w_pop == 1);
            r_key_multi   <= (w_pop >= 2);
        end
    end

    assign o_row         = r_row;
    assign o_key_code    = r_key_code;
    assign o_key_press   = r_key_press;
    assign o_key_release = r_key_release;
    assign o_key_held    = r_key_held;
    assign o_key_multi   = r_key_multi;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench: a simulated key matrix driven frame by frame, a vector
// table, reset-mid-scan sequence and random key traffic against a frame-window model.
module tb_keypad_matrix_scanner;

    localparam int unsigned NR    = 4;
    localparam int unsigned NC    = 4;
    localparam int unsigned SC    = 8;
    localparam int unsigned DF    = 3;
    localparam int unsigned NK    = NR * NC;
    localparam int unsigned FRAME = NR * (SC + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] row;
    logic [NC-1:0] col;
    logic [3:0]    code;
    logic          press;
    logic          rel;
    logic          held;
    logic          multi;
    logic [NK-1:0] keys = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Closed switches connect the driven row to their column
    always_comb begin
        col = '0;
        for (int r = 0; r < int'(NR); r++)
            if (row[r])
                col = col | keys[r*NC +: NC];
    end

    keypad_matrix_scanner #(
        .N_ROWS          (NR),
        .N_COLS          (NC),
        .SETTLE_CYCLES   (SC),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_row         (row),
        .i_col         (col),
        .o_key_code    (code),
        .o_key_press   (press),
        .o_key_release (rel),
        .o_key_held    (held),
        .o_key_multi   (multi)
    );

    // Reference: a frame commits when the last DF frames are identical and
    // differ from the committed key set.
    logic [NK-1:0] m_hist[$];
    logic [NK-1:0] m_deb;
    logic [3:0]    m_code;
    logic          m_press, m_rel, m_held, m_multi;

    task automatic model_reset();
        m_hist.delete();
        m_deb = '0; m_code = '0;
        m_press = 1'b0; m_rel = 1'b0; m_held = 1'b0; m_multi = 1'b0;
    endtask

    task automatic model_frame(input logic [NK-1:0] f);
        bit stable;
        int n;
        m_hist.push_back(f);
        if (m_hist.size() > int'(DF))
            void'(m_hist.pop_front());
        stable = (m_hist.size() == int'(DF));
        foreach (m_hist[i])
            if (m_hist[i] != f) stable = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (stable && (f != m_deb)) begin
            m_deb = f;
            n = $countones(f);
            if (n == 1) begin
                m_press = 1'b1;
                for (int k = 0; k < int'(NK); k++)
                    if (f[k]) m_code = 4'(k);
            end else if (n == 0) begin
                m_rel = 1'b1;
            end
        end
        m_held  = ($countones(m_deb) == 1);
        m_multi = ($countones(m_deb) >= 2);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full scan frame with the given keys closed, starting at a frame boundary
    task automatic run_frame(input logic [NK-1:0] f);
        keys = f;
        for (int j = 1; j <= int'(FRAME); j++) begin
            @(posedge clk);
            #1;
            check("row", 32'(row), 32'(1 << ((j / int'(SC + 1)) % int'(NR))));
            if (j < int'(FRAME)) begin
                check("mid_press", press, 1'b0);
                check("mid_release", rel, 1'b0);
                check("mid_held", held, m_held);
                check("mid_multi", multi, m_multi);
                check("mid_code", code, m_code);
            end
        end
        model_frame(f);
        check("press", press, m_press);
        check("release", rel, m_rel);
        check("code", code, m_code);
        check("held", held, m_held);
        check("multi", multi, m_multi);
    endtask

    typedef struct {
        logic [NK-1:0] keys;
        logic          press;
        logic          rel;
        logic [3:0]    code;
        logic          held;
        logic          multi;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [NK-1:0] k, input logic p, input logic r,
                       input logic [3:0] c, input logic h, input logic m);
        vec_t v;
        v.keys = k; v.press = p; v.rel = r; v.code = c; v.held = h; v.multi = m;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [NK-1:0] cur;
        int a, b;

        // key 6 press, direct switch to 9, release, multi {2,13}, drop to 2, release, bounce on key 0
        add(16'h0040, 0, 0, 0, 0, 0); add(16'h0040, 0, 0, 0, 0, 0); add(16'h0040, 1, 0, 6, 1, 0);
        add(16'h0040, 0, 0, 6, 1, 0); add(16'h0200, 0, 0, 6, 1, 0); add(16'h0200, 0, 0, 6, 1, 0);
        add(16'h0200, 1, 0, 9, 1, 0); add(16'h0000, 0, 0, 9, 1, 0); add(16'h0000, 0, 0, 9, 1, 0);
        add(16'h0000, 0, 1, 9, 0, 0); add(16'h2004, 0, 0, 9, 0, 0); add(16'h2004, 0, 0, 9, 0, 0);
        add(16'h2004, 0, 0, 9, 0, 1); add(16'h0004, 0, 0, 9, 0, 1); add(16'h0004, 0, 0, 9, 0, 1);
        add(16'h0004, 1, 0, 2, 1, 0); add(16'h0000, 0, 0, 2, 1, 0); add(16'h0000, 0, 0, 2, 1, 0);
        add(16'h0000, 0, 1, 2, 0, 0); add(16'h0001, 0, 0, 2, 0, 0); add(16'h0000, 0, 0, 2, 0, 0);
        add(16'h0001, 0, 0, 2, 0, 0); add(16'h0000, 0, 0, 2, 0, 0); add(16'h0001, 0, 0, 2, 0, 0);
        add(16'h0001, 0, 0, 2, 0, 0); add(16'h0001, 1, 0, 0, 1, 0); add(16'h0000, 0, 0, 0, 1, 0);
        add(16'h0000, 0, 0, 0, 1, 0); add(16'h0000, 0, 1, 0, 0, 0);

        model_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_row", 32'(row), 32'h1);
        check("rst_press", press, 1'b0);
        check("rst_release", rel, 1'b0);
        check("rst_held", held, 1'b0);
        check("rst_multi", multi, 1'b0);
        check("rst_code", code, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_frame(tbl[i].keys);
            check("tbl_press", press, tbl[i].press);
            check("tbl_release", rel, tbl[i].rel);
            check("tbl_code", code, tbl[i].code);
            check("tbl_held", held, tbl[i].held);
            check("tbl_multi", multi, tbl[i].multi);
        end

        // Asynchronous reset during the row-2 settle with key 6 committed
        repeat (3) run_frame(16'h0040);
        check("pre_rst_held", held, 1'b1);
        for (int j = 0; j < 21; j++) begin
            @(posedge clk);
            #1;
        end
        check("mid_rst_row_before", 32'(row), 32'h4);
        rst = 1'b1;
        #1;
        check("mid_rst_row", 32'(row), 32'h1);
        check("mid_rst_held", held, 1'b0);
        check("mid_rst_code", code, 4'd0);
        check("mid_rst_release", rel, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_hold_release", rel, 1'b0);
        check("mid_rst_hold_press", press, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_frame(16'h0040);
        run_frame(16'h0040);
        run_frame(16'h0040);
        check("post_rst_press", press, 1'b1);
        check("post_rst_code", code, 4'd6);

        // Random key traffic held for runs of whole frames
        cur = '0;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 99) >= 55) begin
                cur = '0;
                case ($urandom_range(0, 2))
                    0: cur = '0;
                    1: cur[$urandom_range(0, NK - 1)] = 1'b1;
                    default: begin
                        a = int'($urandom_range(0, NK - 1));
                        b = (a + 1 + int'($urandom_range(0, NK - 2))) % int'(NK);
                        cur[a] = 1'b1;
                        cur[b] = 1'b1;
                    end
                endcase
            end
            run_frame(cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised row/column keypad matrix scanner for the iCESugar-nano PMOD keypad demos. It drives one row at a time, samples the synchronised column inputs after a settle delay, and debounces whole scan frames. It then emits one-cycle press/release events with an encoded key index, plus held/multi-key levels. It sits between the PMOD keypad pins and display or consumer logic, such as an LED or segment driver.

## Interface
- N_ROWS, 4: number of matrix rows driven (≥2)
- N_COLS, 4: number of matrix columns sampled (≥1)
- SETTLE_CYCLES, 8: cycles a row is driven before its sample (≥3, covers synchroniser latency)
- DEBOUNCE_FRAMES, 3: consecutive identical frames required to commit a new key state (≥1)
- CODE_W = max(1, clog2(N_ROWS*N_COLS)): derived, not overridable
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- ROW  out  N_ROWS  row drive, one-hot: selected row 1, others 0
- COL  in  N_COLS  column sense, 1 = key closed on the driven row (external pull-downs), asynchronous
- KEY_CODE  out  CODE_W  index of last single key event, row*N_COLS + col
- KEY_PRESS  out  1  one-cycle pulse: new single key committed
- KEY_RELEASE  out  1  one-cycle pulse: keys released to none
- KEY_HELD  out  1  level: exactly one key debounced-pressed
- KEY_MULTI  out  1  level: two or more keys debounced-pressed

## Operation
- COL passes through a 2-flop synchroniser. Scan logic uses only the synchronised value.
- Scan FSM states: SETTLE and SAMPLE.
  - SETTLE: ROW drives current row r. Counter runs 0..SETTLE_CYCLES-1, then goes to SAMPLE.
  - SAMPLE: the synchronised COL is written into frame bits [r*N_COLS +: N_COLS]. Then r advances (wrap N_ROWS-1 → 0), ROW updates, and the FSM returns to SETTLE.
- The frame is complete at the SAMPLE of row N_ROWS-1. At that point the debounce update runs:
  - If frame == prev_frame, stable_cnt increments, saturating at DEBOUNCE_FRAMES. Otherwise stable_cnt is set to 1.
  - prev_frame is then set to frame.
  - Commit when stable_cnt reaches DEBOUNCE_FRAMES (counting this frame) and frame != debounced. Then debounced is set to frame.
- Event on commit, with n = popcount(new debounced):
  - n==1 → KEY_PRESS, KEY_CODE = index of set bit. This covers none→A, A→B direct, and multi→single.
  - n==0 → KEY_RELEASE, KEY_CODE unchanged.
  - n≥2 → no pulse, KEY_CODE unchanged.
- KEY_HELD = (n==1), KEY_MULTI = (n≥2), both taken from the debounced state and registered.
- KEY_PRESS and KEY_RELEASE are never asserted together. Each commit produces at most one pulse.

## Timing
- Reset values:
  - ROW = 1 (row 0 selected), FSM = SETTLE, counters 0
  - frame, prev_frame and debounced all 0, stable_cnt 0
  - KEY_CODE 0, KEY_PRESS 0, KEY_RELEASE 0, KEY_HELD 0, KEY_MULTI 0
- Row period is SETTLE_CYCLES+1 cycles. Frame period F = N_ROWS*(SETTLE_CYCLES+1), which is 36 cycles at the defaults.
- COL-to-sample latency is 2 cycles. COL must be stable from row select to SAMPLE-2.
- Event outputs (KEY_PRESS, KEY_RELEASE, KEY_CODE, KEY_HELD, KEY_MULTI) update on the cycle after the committing last-row SAMPLE.
- A key closed before frame k starts is committed at the end of frame k+DEBOUNCE_FRAMES-1.
- A mismatching frame restarts the count, so a bounce delays the commit. It never causes a spurious event.
- RST mid-scan clears everything immediately (asynchronous). The scan restarts at row 0 on the first clock edge after RST is released. No pulse is generated by reset.

## Structure
- Package keypad_pkg holds:
  - scan state enum {SETTLE, SAMPLE}
  - clog2/CODE_W helper function
  - popcount helper function
- Sub-module keypad_frame_debounce (inputs: frame and frame_done; outputs: debounced, commit) isolates the debounce/commit logic.
- The top level holds the synchroniser, scan FSM, event encoding and output registers.

## Test plan
- Reset: hold RST 5 cycles, then check ROW=0001, all flags 0. Release and check ROW steps 0001→0010→0100→1000→0001 every 9 cycles.
- Single press: close row1/col2 before frame 0. At the end of frame 2, check one KEY_PRESS pulse, KEY_CODE=6, KEY_HELD=1. Check no further pulses while it is held.
- Bounce: toggle row0/col0 in frames 0 and 1, then hold it stable. Check KEY_PRESS (code 0) only 3 frames after the last toggle.
- Direct switch and release: hold key 6, move to key 9. Check KEY_PRESS with KEY_CODE=9. Open all keys and check KEY_RELEASE, KEY_CODE=9, KEY_HELD=0.
- Multi-key: close keys 2 and 13. Check KEY_MULTI=1, KEY_HELD=0, no pulse. Release key 13 and check KEY_PRESS with KEY_CODE=2.
- Reset mid-frame while key 6 is held: assert RST during the row-2 SETTLE. Check outputs clear at once and no RELEASE pulse. After RST is released, check KEY_PRESS code 6 after 3 full frames.
